// File: rtl/alu_control_mdu.sv
// ALU control with funct decode, HI/LO registers and an iterative multiply/divide sequencer.
// Define ALU_CTRL_MULDIV_EN to build the MDU; otherwise MDU functs decode as illegal.
module alu_control_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       op,
    output logic             illegal,
    output logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             div0
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    always_comb begin
        op      = OP_ILL;
        illegal = 1'b0;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_SLT;
            default: begin
                case (funct)
                    6'h20, 6'h21: op = OP_ADD;
                    6'h22, 6'h23: op = OP_SUB;
                    6'h24:        op = OP_AND;
                    6'h25:        op = OP_OR;
                    6'h26:        op = OP_XOR;
                    6'h27:        op = OP_NOR;
                    6'h2A:        op = OP_SLT;
                    6'h2B:        op = OP_SLTU;
`ifdef ALU_CTRL_MULDIV_EN
                    6'h10, 6'h11, 6'h12, 6'h13,
                    6'h18, 6'h19, 6'h1A, 6'h1B: op = OP_ADD;
`endif
                    default:      illegal = 1'b1;
                endcase
            end
        endcase
    end

`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, acc_hi, acc_lo, opb;
    logic               is_div, neg_a, neg_r;
    logic               is_mdu, accept, sgn;
    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [WIDTH:0]     msum, dshift, ddiff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // 0x10-0x13 and 0x18-0x1B: funct[5:4]=01, funct[2]=0
    assign is_mdu   = (alu_op == 2'b10) && (funct[5:4] == 2'b01) && !funct[2];
    assign busy     = (state != S_IDLE);
    assign stall    = issue && is_mdu && busy;
    assign accept   = issue && is_mdu && !busy;
    assign hilo_sel = is_mdu && !funct[3] && !funct[0];
    assign hilo_rd  = !hilo_sel ? '0 : (funct[1] ? lo : hi);

    // funct[0]=0 selects the signed variant of mult/div
    assign sgn    = !funct[0];
    assign abs_rs = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign abs_rt = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign dshift   = {acc_hi, acc_lo[WIDTH-1]};
    assign ddiff    = dshift - {1'b0, opb};
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_a ? -prod : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            div0 <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    case (funct[3:0])
                        4'h1: hi <= rs_val;
                        4'h3: lo <= rs_val;
                        4'h8, 4'h9: begin
                            state  <= S_MUL;
                            is_div <= 1'b0;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= abs_rs;
                            opb    <= abs_rt;
                            neg_a  <= sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        end
                        4'hA, 4'hB: begin
                            if (rt_val == '0) begin
                                hi   <= rs_val;
                                lo   <= '1;
                                div0 <= 1'b1;
                            end else begin
                                state  <= S_DIV;
                                is_div <= 1'b1;
                                cnt    <= '0;
                                acc_hi <= '0;
                                acc_lo <= abs_rs;
                                opb    <= abs_rt;
                                neg_a  <= sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                neg_r  <= sgn && rs_val[WIDTH-1];
                            end
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    acc_hi <= msum[WIDTH:1];
                    acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_DIV: begin
                    acc_hi <= ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], !ddiff[WIDTH]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                default: begin
                    if (is_div) begin
                        lo <= neg_a ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, issue, rs_val, rt_val};
    assign busy      = 1'b0;
    assign stall     = 1'b0;
    assign div0      = 1'b0;
    assign hilo_sel  = 1'b0;
    assign hilo_rd   = '0;
`endif
endmodule
